// File: rtl/sha2_stream_core.sv
// Multi-block SHA-256/SHA-224 compression core with valid/ready block input and digest output.
// Hash state is chained across blocks; ROUNDS_PER_CYCLE rounds are evaluated per clock.
module sha2_stream_core #(
   parameter int ROUNDS_PER_CYCLE = 1,
   parameter bit SUPPORT_224      = 1'b1
) (
   input  logic         clock,
   input  logic         reset,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [511:0] in_block,
   input  logic         in_first,
   input  logic         in_last,
   input  logic         mode_224,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [255:0] out_digest,
   output logic         busy
);

   generate
      if (!(ROUNDS_PER_CYCLE == 1 || ROUNDS_PER_CYCLE == 2 ||
            ROUNDS_PER_CYCLE == 4 || ROUNDS_PER_CYCLE == 8)) begin : g_bad_rounds
         $error("sha2_stream_core: ROUNDS_PER_CYCLE must be 1, 2, 4 or 8");
      end
   endgenerate

   // Index 0 holds a / H0 / W[t]; the window slides toward index 0.
   typedef logic [7:0][31:0]  words8_t;
   typedef logic [15:0][31:0] window_t;
   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ROUND  = 2'd1,
      ST_UPDATE = 2'd2,
      ST_HOLD   = 2'd3
   } state_t;

   localparam logic [5:0] LAST_T = 6'(64 - ROUNDS_PER_CYCLE);
   localparam logic [5:0] R_STEP = 6'(ROUNDS_PER_CYCLE);

   localparam words8_t IV256 = {32'h5be0cd19, 32'h1f83d9ab, 32'h9b05688c, 32'h510e527f,
                                32'ha54ff53a, 32'h3c6ef372, 32'hbb67ae85, 32'h6a09e667};
   localparam words8_t IV224 = {32'hbefa4fa4, 32'h64f98fa7, 32'h68581511, 32'hffc00b31,
                                32'hf70e5939, 32'h3070dd17, 32'h367cd507, 32'hc1059ed8};

   localparam logic [31:0] K [64] = '{
      32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
      32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
      32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
      32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
      32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
      32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
      32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
      32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
   };

   function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
      return (x >> n) | (x << (32 - n));
   endfunction

   function automatic logic [31:0] big_sigma0(input logic [31:0] x);
      return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
   endfunction

   function automatic logic [31:0] big_sigma1(input logic [31:0] x);
      return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
   endfunction

   function automatic logic [31:0] small_sigma0(input logic [31:0] x);
      return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
   endfunction

   function automatic logic [31:0] small_sigma1(input logic [31:0] x);
      return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
   endfunction

   function automatic words8_t sha_round(input words8_t s, input logic [31:0] k, input logic [31:0] w);
      logic [31:0] t1;
      logic [31:0] t2;
      words8_t     n;
      t1   = s[7] + big_sigma1(s[4]) + ((s[4] & s[5]) ^ (~s[4] & s[6])) + k + w;
      t2   = big_sigma0(s[0]) + ((s[0] & s[1]) ^ (s[0] & s[2]) ^ (s[1] & s[2]));
      n[0] = t1 + t2;
      n[1] = s[0];
      n[2] = s[1];
      n[3] = s[2];
      n[4] = s[3] + t1;
      n[5] = s[4];
      n[6] = s[5];
      n[7] = s[6];
      return n;
   endfunction

   function automatic words8_t run_rounds(input words8_t s, input window_t win, input logic [5:0] t);
      words8_t st;
      st = s;
      for (int j = 0; j < ROUNDS_PER_CYCLE; j++) begin
         st = sha_round(st, K[t + 6'(j)], win[j]);
      end
      return st;
   endfunction

   // New words are appended behind the window; later ones may depend on earlier ones.
   function automatic window_t next_window(input window_t win);
      logic [31:0] ext [16 + ROUNDS_PER_CYCLE];
      window_t     nw;
      for (int i = 0; i < 16; i++) begin
         ext[i] = win[i];
      end
      for (int j = 0; j < ROUNDS_PER_CYCLE; j++) begin
         ext[16 + j] = small_sigma1(ext[14 + j]) + ext[9 + j] + small_sigma0(ext[1 + j]) + ext[j];
      end
      for (int i = 0; i < 16; i++) begin
         nw[i] = ext[i + ROUNDS_PER_CYCLE];
      end
      return nw;
   endfunction

   function automatic window_t load_window(input logic [511:0] blk);
      window_t w;
      for (int i = 0; i < 16; i++) begin
         w[i] = blk[511 - 32*i -: 32];
      end
      return w;
   endfunction

   function automatic words8_t add8(input words8_t x, input words8_t y);
      words8_t s;
      for (int i = 0; i < 8; i++) begin
         s[i] = x[i] + y[i];
      end
      return s;
   endfunction

   function automatic logic [255:0] pack_digest(input words8_t h, input logic trunc);
      logic [255:0] d;
      for (int i = 0; i < 7; i++) begin
         d[255 - 32*i -: 32] = h[i];
      end
      d[31:0] = trunc ? 32'h0000_0000 : h[7];
      return d;
   endfunction

   state_t       state_r;
   state_t       state_s;
   logic [5:0]   round_r;
   window_t      w_r;
   words8_t      wv_r;
   words8_t      h_r;
   logic         mode_r;
   logic         last_r;
   logic         in_ready_r;
   logic         out_valid_r;
   logic         busy_r;
   logic [255:0] out_digest_r;

   logic         accept_s;
   logic         use_224_s;
   words8_t      iv_s;
   words8_t      rnd_next_s;
   window_t      win_next_s;
   words8_t      h_sum_s;

   assign accept_s   = in_valid & in_ready_r;
   assign use_224_s  = mode_224 & SUPPORT_224;
   assign iv_s       = use_224_s ? IV224 : IV256;
   assign rnd_next_s = run_rounds(wv_r, w_r, round_r);
   assign win_next_s = next_window(w_r);
   assign h_sum_s    = add8(h_r, wv_r);

   assign in_ready   = in_ready_r;
   assign out_valid  = out_valid_r;
   assign out_digest = out_digest_r;
   assign busy       = busy_r;

   // Next-state decode for the block FSM.
   always_comb begin
      state_s = state_r;
      case (state_r)
         ST_IDLE:   if (accept_s) state_s = ST_ROUND; else state_s = ST_IDLE;
         ST_ROUND:  if (round_r == LAST_T) state_s = ST_UPDATE; else state_s = ST_ROUND;
         ST_UPDATE: if (last_r) state_s = ST_HOLD; else state_s = ST_IDLE;
         ST_HOLD:   if (out_ready) state_s = ST_IDLE; else state_s = ST_HOLD;
         default:   state_s = ST_IDLE;
      endcase
   end

   // State register, registered handshake outputs and the hash datapath.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_r      <= ST_IDLE;
         round_r      <= 6'd0;
         w_r          <= 512'd0;
         wv_r         <= 256'd0;
         h_r          <= IV256;
         mode_r       <= 1'b0;
         last_r       <= 1'b0;
         in_ready_r   <= 1'b1;
         out_valid_r  <= 1'b0;
         busy_r       <= 1'b0;
         out_digest_r <= 256'd0;
      end else begin
         state_r     <= state_s;
         in_ready_r  <= (state_s == ST_IDLE);
         out_valid_r <= (state_s == ST_HOLD);
         busy_r      <= (state_s != ST_IDLE);
         case (state_r)
            ST_IDLE: begin
               if (accept_s) begin
                  round_r <= 6'd0;
                  w_r     <= load_window(in_block);
                  last_r  <= in_last;
                  if (in_first) begin
                     h_r    <= iv_s;
                     wv_r   <= iv_s;
                     mode_r <= use_224_s;
                  end else begin
                     wv_r   <= h_r;
                  end
               end
            end
            ST_ROUND: begin
               wv_r    <= rnd_next_s;
               w_r     <= win_next_s;
               round_r <= round_r + R_STEP;
            end
            ST_UPDATE: begin
               h_r <= h_sum_s;
               if (last_r) begin
                  out_digest_r <= pack_digest(h_sum_s, mode_r);
               end else begin
                  out_digest_r <= out_digest_r;
               end
            end
            ST_HOLD: begin
               out_digest_r <= out_digest_r;
            end
            default: begin
               round_r <= 6'd0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_sha2_stream_core.sv
// Bench for sha2_stream_core: four instances (1, 2, 4, 8 rounds per clock) driven from a
// vector table, with a digest/latency scoreboard and hand-written backpressure and reset sequences.
module tb_sha2_stream_core;

   typedef struct {
      int           inst;
      logic [511:0] blk;
      bit           first;
      bit           last;
      bit           mode;
      logic [255:0] dig;
   } vec_t;

   typedef struct {
      logic [255:0] dig;
      int           lat;
      int           acc;
      int           inst;
   } exp_t;

   logic         clock;
   logic         reset;
   logic [511:0] in_block;
   logic         in_first;
   logic         in_last;
   logic         mode_224;
   logic         in_valid_a   [4];
   logic         in_ready_a   [4];
   logic         out_valid_a  [4];
   logic         out_ready_a  [4];
   logic [255:0] out_digest_a [4];
   logic         busy_a       [4];

   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;
   int   hs_count = 0;
   int   hs_edge = 0;
   bit   ov_prev [4] = '{default: 1'b0};
   exp_t sb [$];

   int   prev_acc = 0;
   int   prev_inst = -1;
   bit   prev_last = 1'b1;

   localparam logic [255:0] D_ABC256 = 256'hba7816bf_8f01cfea_414140de_5dae2223_b00361a3_96177a9c_b410ff61_f20015ad;
   localparam logic [255:0] D_EMPTY  = 256'he3b0c442_98fc1c14_9afbf4c8_996fb924_27ae41e4_649b934c_a495991b_7852b855;
   localparam logic [255:0] D_TWO    = 256'h248d6a61_d20638b8_e5c02693_0c3e6039_a33ce459_64ff2167_f6ecedd4_19db06c1;
   localparam logic [255:0] D_ABC224 = 256'h23097d22_3405d822_8642a477_bda255b3_2aadbce4_bda0b3f7_e36c9da7_00000000;

   logic [511:0] abc_blk;
   logic [511:0] empty_blk;
   logic [511:0] two1_blk;
   logic [511:0] two2_blk;
   vec_t         vecs [8];

   for (genvar g = 0; g < 4; g++) begin : g_dut
      sha2_stream_core #(
         .ROUNDS_PER_CYCLE(1 << g),
         .SUPPORT_224     (1'b1)
      ) dut (
         .clock     (clock),
         .reset     (reset),
         .in_valid  (in_valid_a[g]),
         .in_ready  (in_ready_a[g]),
         .in_block  (in_block),
         .in_first  (in_first),
         .in_last   (in_last),
         .mode_224  (mode_224),
         .out_valid (out_valid_a[g]),
         .out_ready (out_ready_a[g]),
         .out_digest(out_digest_a[g]),
         .busy      (busy_a[g])
      );
   end

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   initial begin
      forever begin
         @(posedge clock);
         cyc++;
      end
   end

   task automatic chk(input string name, input logic [255:0] got, input logic [255:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s got %h want %h", name, got, want);
      end
   endtask

   // Scoreboard: latency checked on out_valid rise, digest checked on handshake.
   initial begin
      forever begin
         @(negedge clock);
         for (int i = 0; i < 4; i++) begin
            if (out_valid_a[i] === 1'b1 && !ov_prev[i]) begin
               if (sb.size() == 0 || sb[0].inst != i) begin
                  checks++;
                  errors++;
                  $display("FAIL unexpected_out_valid inst %0d got 1 want 0", i);
               end else begin
                  chk("latency", 256'((cyc + 1) - sb[0].acc), 256'(sb[0].lat));
               end
            end
            if (out_valid_a[i] === 1'b1 && out_ready_a[i] === 1'b1) begin
               hs_count++;
               hs_edge = cyc + 1;
               if (sb.size() > 0 && sb[0].inst == i) begin
                  exp_t e;
                  e = sb.pop_front();
                  chk("digest", out_digest_a[i], e.dig);
               end
            end
            ov_prev[i] = (out_valid_a[i] === 1'b1);
         end
      end
   end

   task automatic send(input int inst, input logic [511:0] blk, input bit first, input bit last,
                       input bit mode, output int acc);
      int n;
      n = 0;
      @(negedge clock);
      in_block = blk;
      in_first = first;
      in_last  = last;
      mode_224 = mode;
      in_valid_a[inst] = 1'b1;
      while (in_ready_a[inst] !== 1'b1 && n < 300) begin
         @(negedge clock);
         n++;
      end
      chk("accept_timeout", 256'(n >= 300), 256'd0);
      acc = cyc + 1;
      @(posedge clock);
      #1;
      in_valid_a[inst] = 1'b0;
      for (int k = 0; k < 16; k++) in_block[32*k +: 32] = $urandom();
      in_first = 1'($urandom());
      in_last  = 1'($urandom());
      mode_224 = 1'($urandom());
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (sb.size() > 0 && n < 400) begin
         @(negedge clock);
         n++;
      end
      chk("drain_timeout", 256'(sb.size()), 256'd0);
      @(negedge clock);
   endtask

   task automatic run_vec(input vec_t v);
      int   acc;
      int   rate;
      exp_t e;
      rate = 64 / (1 << v.inst) + 2;
      send(v.inst, v.blk, v.first, v.last, v.mode, acc);
      if (!prev_last && prev_inst == v.inst) begin
         chk("throughput", 256'(acc - prev_acc), 256'(rate));
      end
      if (v.last) begin
         e.dig  = v.dig;
         e.lat  = rate;
         e.acc  = acc;
         e.inst = v.inst;
         sb.push_back(e);
         drain();
      end
      prev_acc  = acc;
      prev_inst = v.inst;
      prev_last = v.last;
   endtask

   initial begin
      int   acc;
      int   n;
      int   hs0;
      exp_t e;

      abc_blk   = {32'h61626380, {14{32'h00000000}}, 32'h00000018};
      empty_blk = {32'h80000000, {15{32'h00000000}}};
      two1_blk  = {32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
                   32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
                   32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
                   32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
      two2_blk  = {{15{32'h00000000}}, 32'h000001c0};

      vecs[0] = '{inst: 0, blk: abc_blk,   first: 1'b1, last: 1'b1, mode: 1'b0, dig: D_ABC256};
      vecs[1] = '{inst: 2, blk: empty_blk, first: 1'b1, last: 1'b1, mode: 1'b0, dig: D_EMPTY};
      vecs[2] = '{inst: 3, blk: abc_blk,   first: 1'b1, last: 1'b1, mode: 1'b1, dig: D_ABC224};
      vecs[3] = '{inst: 3, blk: abc_blk,   first: 1'b1, last: 1'b1, mode: 1'b0, dig: D_ABC256};
      vecs[4] = '{inst: 1, blk: two1_blk,  first: 1'b1, last: 1'b0, mode: 1'b0, dig: 256'd0};
      vecs[5] = '{inst: 1, blk: two2_blk,  first: 1'b0, last: 1'b1, mode: 1'b1, dig: D_TWO};
      vecs[6] = '{inst: 2, blk: abc_blk,   first: 1'b0, last: 1'b1, mode: 1'b0, dig: D_ABC256};
      vecs[7] = '{inst: 0, blk: abc_blk,   first: 1'b1, last: 1'b1, mode: 1'b0, dig: D_ABC256};

      reset    = 1'b1;
      in_block = 512'd0;
      in_first = 1'b0;
      in_last  = 1'b0;
      mode_224 = 1'b0;
      for (int i = 0; i < 4; i++) begin
         in_valid_a[i]  = 1'b0;
         out_ready_a[i] = 1'b1;
      end
      repeat (3) @(posedge clock);
      #1 reset = 1'b0;
      @(negedge clock);
      for (int i = 0; i < 4; i++) begin
         chk("rst_in_ready",   256'(in_ready_a[i]),  256'd1);
         chk("rst_out_valid",  256'(out_valid_a[i]), 256'd0);
         chk("rst_busy",       256'(busy_a[i]),      256'd0);
         chk("rst_out_digest", out_digest_a[i],      256'd0);
      end

      for (int i = 0; i < 6; i++) run_vec(vecs[i]);

      // Backpressure on the R=4 instance with the next block already offered.
      @(posedge clock);
      #1 out_ready_a[2] = 1'b0;
      send(2, abc_blk, 1'b1, 1'b1, 1'b0, acc);
      e.dig = D_ABC256; e.lat = 18; e.acc = acc; e.inst = 2;
      sb.push_back(e);
      n = 0;
      @(negedge clock);
      while (out_valid_a[2] !== 1'b1 && n < 100) begin
         @(negedge clock);
         n++;
      end
      chk("hold_timeout", 256'(n >= 100), 256'd0);
      in_block = empty_blk;
      in_first = 1'b1;
      in_last  = 1'b1;
      mode_224 = 1'b0;
      in_valid_a[2] = 1'b1;
      hs0 = hs_count;
      for (int k = 0; k < 20; k++) begin
         @(negedge clock);
         chk("bp_digest_stable", out_digest_a[2],      D_ABC256);
         chk("bp_in_ready",      256'(in_ready_a[2]),  256'd0);
         chk("bp_out_valid",     256'(out_valid_a[2]), 256'd1);
      end
      @(posedge clock);
      #1 out_ready_a[2] = 1'b1;
      n = 0;
      @(negedge clock);
      while (in_ready_a[2] !== 1'b1 && n < 20) begin
         @(negedge clock);
         n++;
      end
      acc = cyc + 1;
      chk("bp_single_handshake", 256'(hs_count - hs0), 256'd1);
      chk("bp_accept_after_hold", 256'(acc), 256'(hs_edge + 1));
      e.dig = D_EMPTY; e.lat = 18; e.acc = acc; e.inst = 2;
      sb.push_back(e);
      @(posedge clock);
      #1 in_valid_a[2] = 1'b0;
      drain();

      // Reset at round 30 of a first block on the R=1 instance.
      send(0, abc_blk, 1'b1, 1'b1, 1'b0, acc);
      repeat (30) @(posedge clock);
      chk("busy_mid_round", 256'(busy_a[0]), 256'd1);
      #1 reset = 1'b1;
      @(posedge clock);
      #1 reset = 1'b0;
      @(negedge clock);
      chk("abort_in_ready",   256'(in_ready_a[0]),  256'd1);
      chk("abort_out_valid",  256'(out_valid_a[0]), 256'd0);
      chk("abort_busy",       256'(busy_a[0]),      256'd0);
      chk("abort_out_digest", out_digest_a[0],      256'd0);

      prev_last = 1'b1;
      for (int i = 6; i < 8; i++) run_vec(vecs[i]);

      repeat (5) @(negedge clock);
      chk("sb_empty_end", 256'(sb.size()), 256'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
